// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// The RR_ARB_TIMEOUT_EN macro enables the forced-release hold counter in the top.
package rr_arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int SEL_W      = 2;
  localparam int HOLD_CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side bundle of the round-robin mux arbiter.
// Handshake: a requester holds req[i] high for as long as it wants the path;
// it owns the path while gnt[i] is high, and y/y_valid reflect the owner's
// data in the same cycle. Dropping req[i] releases the grant on the next edge.
// With RR_ARB_TIMEOUT_EN defined, a timeout pulse marks a forced release.
// state and ptr are exported so checkers can observe the arbiter FSM.
interface rr_mux_arbiter_if
  import rr_arb_pkg::*;
#(
  parameter int DW = 8
);
  logic [NUM_REQ-1:0] req;
  logic [DW-1:0]      a;
  logic [DW-1:0]      b;
  logic [DW-1:0]      c;
  logic [DW-1:0]      d;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic [DW-1:0]      y;
  logic               y_valid;
  arb_state_t         state;
  logic [SEL_W-1:0]   ptr;
`ifdef RR_ARB_TIMEOUT_EN
  logic               timeout;
`endif

  modport master (
    output req, a, b, c, d,
    input  gnt, sel, y, y_valid, state, ptr
`ifdef RR_ARB_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  req, a, b, c, d,
    output gnt, sel, y, y_valid, state, ptr
`ifdef RR_ARB_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational rotating-priority picker: returns the first set request
// bit scanning from ptr upward, wrapping modulo NUM_REQ.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan ptr, ptr+1, ... and keep the first hit; later hits are ignored.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + i[SEL_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 data mux.
// One owner at a time; the grant is held while its request stays high,
// followed by one IDLE bubble cycle before the next grant.
// Optional: RR_ARB_TIMEOUT_EN forces release after MAX_HOLD BUSY cycles.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  rr_mux_arbiter_if.slave  bus
);

  // Catch illegal configurations at elaboration time.
  if (DW < 1) begin : g_bad_dw
    $error("rr_mux_arbiter: DW must be at least 1");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_mux_arbiter: MAX_HOLD must be in 2..255");
  end

  arb_state_t         state;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   ptr;
  logic               found;
  logic [SEL_W-1:0]   idx;
  logic [DW-1:0]      y_mux;
  logic               y_valid;
`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  timeout;
`endif

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (found),
    .idx   (idx)
  );

  // Arbiter FSM: IDLE picks a winner from ptr, BUSY holds until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= NUM_REQ'(1) << idx;
            sel      <= idx;
            state    <= BUSY;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            gnt <= '0;
          end
        end
        BUSY: begin
          if (!bus.req[sel]) begin
            // Voluntary release: next search starts just past the owner.
            gnt   <= '0;
            state <= IDLE;
            ptr   <= sel + 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          end else if (hold_cnt == HOLD_LAST) begin
            // Forced release puts the owner last in the rotation.
            gnt     <= '0;
            state   <= IDLE;
            ptr     <= sel + 1'b1;
            timeout <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign y_valid = |gnt;

  // Output mux driven by the registered select; forced to zero without a grant.
  always_comb begin
    y_mux = '0;
    if (y_valid) begin
      case (sel)
        2'd0:    y_mux = bus.a;
        2'd1:    y_mux = bus.b;
        2'd2:    y_mux = bus.c;
        default: y_mux = bus.d;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.sel     = sel;
  assign bus.y       = y_mux;
  assign bus.y_valid = y_valid;
  assign bus.state   = state;
  assign bus.ptr     = ptr;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.timeout = timeout;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter; the timeout scenario runs only when
// RR_ARB_TIMEOUT_EN is defined (DUT then built with MAX_HOLD=4).
module tb_rr_mux_arbiter;
  import rr_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [7:0] dat [4];

  rr_mux_arbiter_if #(.DW(8)) bus ();

`ifdef RR_ARB_TIMEOUT_EN
  rr_mux_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`else
  rr_mux_arbiter #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    check("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic drive_data();
    bus.a = dat[0];
    bus.b = dat[1];
    bus.c = dat[2];
    bus.d = dat[3];
  endtask

  task automatic check_owner(input string tag, input int owner);
    check({tag, "_gnt"},   32'(bus.gnt), 32'(1) << owner);
    check({tag, "_sel"},   32'(bus.sel), 32'(owner));
    check({tag, "_y"},     32'(bus.y), 32'(dat[owner]));
    check({tag, "_valid"}, 32'(bus.y_valid), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int exp_ptr);
    check({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    check({tag, "_valid"}, 32'(bus.y_valid), 32'd0);
    check({tag, "_y"},     32'(bus.y), 32'd0);
    check({tag, "_state"}, 32'(bus.state), 32'(IDLE));
    check({tag, "_ptr"},   32'(bus.ptr), 32'(exp_ptr));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h44;
    drive_data();
    bus.req = 4'b1111;
    rst_n   = 1'b0;

    // Reset with all requests active
    repeat (2) step();
    check_idle("rst", 0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    rst_n = 1'b1;
    check_idle("rst_rel", 0);

    // First grant goes to requester 0 one edge after release; then rotate
    step();
    for (int k = 0; k < 5; k++) begin
      check_owner($sformatf("rot%0d", k), k % 4);
      if (k < 4) begin
        step();
        check_owner($sformatf("rot%0d_h1", k), k % 4);
        step();
        check_owner($sformatf("rot%0d_h2", k), k % 4);
        bus.req[k % 4] = 1'b0;
        step();
        check_idle($sformatf("rot%0d_gap", k), (k + 1) % 4);
        bus.req = 4'b1111;
        step();
      end
    end
    bus.req = 4'b0000;
    step();
    check_idle("rot_end", 1);

    // Single requester; data change reaches y in the same cycle
    bus.req = 4'b0100;
    step();
    check_owner("single", 2);
    dat[2] = 8'h5A;
    drive_data();
    #1;
    check("single_ydata", 32'(bus.y), 32'h5A);
    bus.req = 4'b0000;
    step();
    check_idle("single_rel", 3);
    dat[2] = 8'hA5;
    drive_data();

    // Wrap: ptr=3 picks requester 3, then ptr=0 picks requester 0
    bus.req = 4'b1001;
    step();
    check_owner("wrap3", 3);
    bus.req = 4'b0000;
    step();
    check_idle("wrap3_rel", 0);
    bus.req = 4'b1001;
    step();
    check_owner("wrap0", 0);
    bus.req = 4'b0000;
    step();
    check_idle("wrap0_rel", 1);

    // Async reset mid-BUSY, then ptr restarts at 0
    bus.req = 4'b0100;
    step();
    check_owner("arst_pre", 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("arst", 0);
    #1;
    rst_n   = 1'b1;
    bus.req = 4'b0110;
    step();
    check_owner("arst_post", 1);
    bus.req = 4'b0000;
    step();
    check_idle("arst_rel", 2);

`ifdef RR_ARB_TIMEOUT_EN
    // Timeout: requester 0 held 4 BUSY cycles, forced off, then requester 1
    bus.req = 4'b0011;
    step();
    check_owner("to_g0", 0);
    check("to_pulse0", 32'(bus.timeout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_owner($sformatf("to_hold%0d", i), 0);
      check($sformatf("to_quiet%0d", i), 32'(bus.timeout), 32'd0);
    end
    step();
    check_idle("to_force", 1);
    check("to_pulse", 32'(bus.timeout), 32'd1);
    step();
    check_owner("to_g1", 1);
    check("to_pulse_end", 32'(bus.timeout), 32'd0);
`else
    // Without the timeout feature a grant is held indefinitely
    bus.req = 4'b0011;
    step();
    check_owner("hold_g0", 0);
    repeat (20) step();
    check_owner("hold_long", 0);
    check("hold_state", 32'(bus.state), 32'(BUSY));
`endif
    bus.req = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 data mux.
- Four requesters compete for a single output path.
- The block grants one requester at a time, drives the mux select from the grant, and presents the selected data with a valid flag.
- Sits between the requester-side logic and the shared 4:1 mux datapath; owns its select lines exclusively.

Parameters:
- DW, 8, width of each requester data input and of y.
- MAX_HOLD, 16, maximum consecutive BUSY cycles per grant; used only when RR_ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i (a=0, b=1, c=2, d=3).
- a  input  DW  data of requester 0.
- b  input  DW  data of requester 1.
- c  input  DW  data of requester 2.
- d  input  DW  data of requester 3.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select of current owner, registered (s1 = sel[1], s0 = sel[0]).
- y  output  DW  selected data; combinational from registered sel.
- y_valid  output  1  high while a grant is active (= |gnt).
- timeout  output  1  one-cycle pulse on forced release; present only with RR_ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, gnt=4'b0000, sel=2'b00, ptr=2'b00, hold_cnt=0, timeout=0.
  - y=0, y_valid=0.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE; gnt=0.
  - Otherwise pick the first set req bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: gnt=onehot(winner), sel=winner, state=BUSY.
  - Grant latency: 1 clock from the first edge that samples req set.
- BUSY:
  - While req[sel]=1, hold gnt and sel unchanged; other requests are ignored.
  - When req[sel] is sampled 0: next edge gnt=0, state=IDLE, ptr=sel+1 mod 4 (wraps 3->0).
  - The mandatory IDLE bubble cycle is the handoff gap; the earliest next grant comes one further edge later.
- Output path:
  - y = a/b/c/d per sel when y_valid=1; y=0 when y_valid=0.
  - No data register; data changes propagate to y in the same cycle.
- Simultaneous requests: resolved strictly by rotating priority from ptr; no requester waits more than 3 foreign grants.
- A requester that drops req in the same cycle it would be granted is not considered; arbitration uses sampled req only.
- gnt is always one-hot or zero, never multi-hot.
- Asserting rst_n low mid-grant drops gnt immediately (async) and returns all state to reset values; ptr returns to 0.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (8 bit) clears on entry to BUSY and increments each BUSY cycle.
  - When hold_cnt==MAX_HOLD-1 and req[sel] is still 1, the next edge forces the same transition as release: gnt=0, state=IDLE, ptr=sel+1.
  - timeout pulses high for exactly that one cycle (the IDLE cycle).
  - The forced requester may re-request, but rotation places it last.
- Undefined: no counter, no timeout port; a grant is held indefinitely while req stays high.

Decomposition:
- Package rr_arb_pkg:
  - NUM_REQ=4, SEL_W=2.
  - State enum arb_state_t {IDLE, BUSY}.
  - HOLD_CNT_W=8.
- Sub-module rr_pick:
  - Purely combinational rotating-priority picker.
  - Inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0].
  - Instantiated once in the IDLE decision path.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> gnt=0, sel=0, y_valid=0, y=0. After release, the first grant goes to requester 0 one edge later.
- Single requester: req=4'b0100, c=8'hA5 -> gnt=4'b0100 and sel=2 after 1 edge, y=8'hA5, y_valid=1. Drop req -> gnt=0 next edge, ptr=3.
- Rotation: req=4'b1111 held, each owner drops req for 1 cycle after 3 BUSY cycles then re-asserts -> grant order 0,1,2,3,0. Exactly one IDLE cycle between consecutive grants.
- Wrap/priority: ptr=3 (last owner 2), req=4'b1001 -> requester 3 granted. After its release, req=4'b1001 -> requester 0 granted.
- Async reset mid-BUSY: owner 2 granted, rst_n pulses low between edges -> gnt=0 and y_valid=0 without waiting for an edge. Next grant with req=4'b0110 goes to requester 1 (ptr=0).
- Timeout (macro on, MAX_HOLD=4): req=4'b0011 held constantly -> requester 0 is BUSY 4 cycles, then gnt=0 with timeout=1 for one cycle, then requester 1 granted.
